data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised successor to the single-cycle 16-bit data RAM, with byte addressing and byte/halfword accesses (LB/LBU/SB alongside LW/SW). Reads are sign- or zero-extended. The block adds configurable wait states, and a stall output that freezes the MEM stage while an access is in flight. Illegal accesses are reported through an error pulse. The block sits in the MEM stage between the EX/MEM and MEM/WB pipeline registers.

Parameters:
DEPTH, 512, number of 16-bit words; power of two, minimum 2.
ADDR_WIDTH, 16, width of the byte address from the ALU result.
WAIT_CYCLES, 1, extra cycles between accepting a request and its response; 0 to 15.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active low
req_valid  in  1  MEM-stage access request; held stable while stall=1
req_write  in  1  1 = store, 0 = load
req_size  in  1  0 = byte, 1 = halfword
req_signed  in  1  loads only: 1 = sign-extend a byte, 0 = zero-extend
addr  in  ADDR_WIDTH  byte address
wdata  in  16  store data; a byte store uses wdata[7:0]
stall  out  1  freeze the pipeline
rdata  out  16  load result, valid only while rdata_valid=1, otherwise 0
rdata_valid  out  1  one-cycle pulse for a completed load
access_err  out  1  one-cycle pulse for a misaligned or out-of-range access

Behaviour:
- Storage: DEPTH x 16 words, word index = addr[log2(DEPTH):1], byte lane = addr[0]. Lane 0 is bits [7:0] (little-endian). Initial contents are zero. Reset does not clear the array.
- Reset (rst_n=0 at a clk edge): state=IDLE, wait counter=0, latched request cleared. stall, rdata, rdata_valid and access_err are all 0.
- Reset mid-operation: the pending request is dropped. A store that has not reached RESP never writes.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, req_valid=1: latch req_write, req_size, req_signed, addr and wdata; load the counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: decrement the counter; go to RESP when it reaches 1.
  - RESP: go to IDLE unconditionally.
- stall = (state==IDLE and req_valid) or state==WAIT. stall is combinational and is 0 in RESP, so the pipeline advances on the edge that closes RESP.
- Latency: request in cycle 0 → response in cycle WAIT_CYCLES+1. A request presented while in RESP is the one completing and is not re-accepted. The next request is accepted in IDLE one cycle later. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Error checks, evaluated on latched values:
  - misaligned: req_size=1 and addr[0]=1.
  - out of range: any addr bit above bit log2(DEPTH) is set.
  - On error, in RESP: access_err=1, no write, rdata=0, rdata_valid=0.
- Store in RESP (no error): the write commits on the rising edge ending RESP.
  - Halfword store: the whole word is written.
  - Byte store: only the selected lane is written; the other lane is unchanged.
- Load in RESP (no error): rdata_valid=1.
  - Halfword load: rdata = the word.
  - Byte load: rdata = the selected lane, extended per req_signed.
- rdata is driven from a registered read of the latched address, or from a combinational read of it. Either is acceptable provided the value is correct in RESP.
- Ordering: the RAM is read in the same RESP cycle as any earlier store, so the new data is visible to the next access.

Decomposition:
- Shared package (mem_pkg): size encodings SIZE_BYTE and SIZE_HALF; state encodings; the helper computing the word-index width from DEPTH.
- One sub-module: mem_array_bytewe, a DEPTH x 16 RAM with a 2-bit byte write-enable and an asynchronous read.
- The FSM, checks and extension logic stay in data_memory_ctrl.

Test Plan:
- WAIT_CYCLES=1: SW addr=0x0010 wdata=0xBEEF, then LW addr=0x0010 → stall high for cycles 0–1, RESP in cycle 2, rdata=0xBEEF, rdata_valid pulse of 1 cycle.
- SB addr=0x0011 wdata=0x0080, then LB signed addr=0x0011 → rdata=0xFF80; LBU same address → 0x0080; LW addr=0x0010 → 0x80EF.
- LW addr=0x0013 (misaligned) and SW addr=0x0400 with DEPTH=512 (out of range) → access_err pulse, rdata=0, no memory change (a read-back of word 0 is unchanged).
- WAIT_CYCLES=0, two back-to-back loads → each responds in cycle 1; the second is accepted only after IDLE, never double-accepted in RESP.
- SW issued, then rst_n=0 during WAIT → no write (read-back still 0); all outputs 0 the cycle after reset.
- WAIT_CYCLES=3 sweep → stall high exactly 4 cycles per access; RESP in cycle 4.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory controller:
// access size codes, FSM state codes and the word-index width helper.
package mem_pkg;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_HALF = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Bits needed to index DEPTH 16-bit words (at least 1).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// MEM-stage access bus between the pipeline (master) and the memory
// controller (slave): request fields in, stall/load result/error out.
interface data_memory_ctrl_if #(
    parameter int ADDR_WIDTH = 16
) ();

    logic                  req_valid;
    logic                  req_write;
    logic                  req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           wdata;
    logic                  stall;
    logic [15:0]           rdata;
    logic                  rdata_valid;
    logic                  access_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, addr, wdata,
        input  stall, rdata, rdata_valid, access_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, addr, wdata,
        output stall, rdata, rdata_valid, access_err
    );

endinterface

// File: rtl/data_memory_ctrl_mem_array_bytewe.sv
// DEPTH x 16 RAM with per-byte write enables and asynchronous read.
// Ports: clk, we_i[1:0] (lane enables), addr_i (word index), wdata_i, rdata_o.
module mem_array_bytewe #(
    parameter int DEPTH = 512,
    parameter int IW    = 9
) (
    input  logic          clk,
    input  logic [1:0]    we_i,
    input  logic [IW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
        if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory controller: byte/halfword loads and stores with
// wait states and stall. Ports: clk, rst_n (sync, low), bus (slave side).
module data_memory_ctrl #(
    parameter int DEPTH       = 512,
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input logic               clk,
    input logic               rst_n,
    data_memory_ctrl_if.slave bus
);

    import mem_pkg::*;

    localparam int IW = idx_width(DEPTH);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;

    logic        in_resp;
    logic        oor;
    logic        mis;
    logic        err;
    logic [1:0]  we;
    logic [15:0] mem_wdata;
    logic [15:0] word;
    logic [7:0]  lane;
    logic [15:0] load_val;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    size_d  = bus.req_size;
                    sgn_d   = bus.req_signed;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Any byte-address bit beyond the array is out of range.
    if (ADDR_WIDTH > IW + 1) begin : g_oor
        assign oor = |addr_q[ADDR_WIDTH-1:IW+1];
    end else begin : g_no_oor
        assign oor = 1'b0;
    end

    assign in_resp = (state_q == ST_RESP);
    assign mis     = (size_q == SIZE_HALF) && addr_q[0];
    assign err     = mis || oor;

    // Byte stores replicate the byte so either lane can take it.
    always_comb begin
        we = 2'b00;
        if (in_resp && wr_q && !err) begin
            if (size_q == SIZE_HALF) we = 2'b11;
            else                     we = addr_q[0] ? 2'b10 : 2'b01;
        end
    end

    assign mem_wdata = (size_q == SIZE_HALF) ? wdata_q
                                             : {wdata_q[7:0], wdata_q[7:0]};

    mem_array_bytewe #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .addr_i  (addr_q[IW:1]),
        .wdata_i (mem_wdata),
        .rdata_o (word)
    );

    assign lane     = addr_q[0] ? word[15:8] : word[7:0];
    assign load_val = (size_q == SIZE_HALF) ? word
                    : sgn_q ? {{8{lane[7]}}, lane}
                    : {8'h00, lane};

    assign bus.stall       = ((state_q == ST_IDLE) && bus.req_valid)
                           || (state_q == ST_WAIT);
    assign bus.rdata_valid = in_resp && !wr_q && !err;
    assign bus.access_err  = in_resp && err;
    assign bus.rdata       = bus.rdata_valid ? load_val : 16'h0000;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: three instances (0, 1, 3 wait
// states) checked against a byte-addressed reference memory.
module tb_data_memory_ctrl;

    typedef struct {
        bit          err;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int          sel = 1;
    logic        rv = 1'b0;
    logic        wr = 1'b0;
    logic        sz = 1'b0;
    logic        sg = 1'b0;
    logic [15:0] ad = '0;
    logic [15:0] wd = '0;

    logic        m_stall;
    logic [15:0] m_rdata;
    logic        m_rv;
    logic        m_err;

    int errs = 0;
    int checks = 0;

    exp_t q[$];
    logic [7:0] mdl [3][1024];

    always #5 clk = ~clk;

    data_memory_ctrl_if #(.ADDR_WIDTH(16)) if0 ();
    data_memory_ctrl_if #(.ADDR_WIDTH(16)) if1 ();
    data_memory_ctrl_if #(.ADDR_WIDTH(16)) if3 ();

    assign if0.req_valid  = rv && (sel == 0);
    assign if1.req_valid  = rv && (sel == 1);
    assign if3.req_valid  = rv && (sel == 2);
    assign if0.req_write  = wr;
    assign if1.req_write  = wr;
    assign if3.req_write  = wr;
    assign if0.req_size   = sz;
    assign if1.req_size   = sz;
    assign if3.req_size   = sz;
    assign if0.req_signed = sg;
    assign if1.req_signed = sg;
    assign if3.req_signed = sg;
    assign if0.addr       = ad;
    assign if1.addr       = ad;
    assign if3.addr       = ad;
    assign if0.wdata      = wd;
    assign if1.wdata      = wd;
    assign if3.wdata      = wd;

    data_memory_ctrl #(.DEPTH(512), .ADDR_WIDTH(16), .WAIT_CYCLES(0))
        u_w0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    data_memory_ctrl #(.DEPTH(512), .ADDR_WIDTH(16), .WAIT_CYCLES(1))
        u_w1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    data_memory_ctrl #(.DEPTH(512), .ADDR_WIDTH(16), .WAIT_CYCLES(3))
        u_w3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    always_comb begin
        m_stall = if1.stall;
        m_rdata = if1.rdata;
        m_rv    = if1.rdata_valid;
        m_err   = if1.access_err;
        if (sel == 0) begin
            m_stall = if0.stall;
            m_rdata = if0.rdata;
            m_rv    = if0.rdata_valid;
            m_err   = if0.access_err;
        end else if (sel == 2) begin
            m_stall = if3.stall;
            m_rdata = if3.rdata;
            m_rv    = if3.rdata_valid;
            m_err   = if3.access_err;
        end
    end

    function automatic int waits(input int s);
        return (s == 0) ? 0 : (s == 1) ? 1 : 3;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, want, $time);
        end
    endtask

    // Monitor: every DUT response is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (m_rv || m_err) begin
            if (q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL spurious_resp: rv=%0b err=%0b rdata=%0h",
                         m_rv, m_err, m_rdata);
            end else begin
                e = q.pop_front();
                check("resp_kind", {30'd0, m_rv, m_err},
                      e.err ? 32'd1 : 32'd2);
                check("rdata", {16'd0, m_rdata}, {16'd0, e.data});
            end
        end else begin
            check("rdata_idle", {16'd0, m_rdata}, 32'd0);
        end
    end

    task automatic access(input int s, input bit w, input bit size,
                          input bit sgn, input logic [15:0] a,
                          input logic [15:0] d);
        exp_t e;
        bit er;
        int n;
        logic [7:0] b;
        @(negedge clk);
        sel = s;
        rv = 1'b1;
        wr = w;
        sz = size;
        sg = sgn;
        ad = a;
        wd = d;
        er = (size && a[0]) || (a >= 16'd1024);
        e.err = er;
        e.data = 16'h0000;
        if (!er && w) begin
            mdl[s][a] = d[7:0];
            if (size) mdl[s][a + 1] = d[15:8];
        end else if (!er) begin
            b = mdl[s][a];
            if (size)     e.data = {mdl[s][a + 1], b};
            else if (sgn) e.data = {{8{b[7]}}, b};
            else          e.data = {8'h00, b};
        end
        if (er || !w) q.push_back(e);
        n = 0;
        #1;
        while (m_stall && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", n, waits(s) + 1);
        check("resp_present", {31'd0, m_rv | m_err}, {31'd0, er | !w});
    endtask

    task automatic idle();
        @(negedge clk);
        rv = 1'b0;
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_stall0"}, {31'd0, if0.stall}, 0);
        check({nm, "_out0"}, {if0.rdata, 14'd0, if0.rdata_valid,
              if0.access_err}, 0);
        check({nm, "_stall1"}, {31'd0, if1.stall}, 0);
        check({nm, "_out1"}, {if1.rdata, 14'd0, if1.rdata_valid,
              if1.access_err}, 0);
        check({nm, "_stall3"}, {31'd0, if3.stall}, 0);
        check({nm, "_out3"}, {if3.rdata, 14'd0, if3.rdata_valid,
              if3.access_err}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w;
        bit s1;
        bit s2;
        logic [15:0] a;
        for (int m = 0; m < 3; m++)
            for (int i = 0; i < 1024; i++) mdl[m][i] = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Word store/load and lane behaviour.
        access(1, 1, 1, 0, 16'h0010, 16'hBEEF);
        access(1, 0, 1, 0, 16'h0010, 16'h0000);
        access(1, 1, 0, 0, 16'h0011, 16'h0080);
        access(1, 0, 0, 1, 16'h0011, 16'h0000);
        access(1, 0, 0, 0, 16'h0011, 16'h0000);
        access(1, 0, 1, 0, 16'h0010, 16'h0000);

        // Errors leave memory untouched (0x0400 aliases word 0).
        access(1, 1, 1, 0, 16'h0000, 16'h1111);
        access(1, 0, 1, 0, 16'h0013, 16'h0000);
        access(1, 1, 1, 0, 16'h0400, 16'hDEAD);
        access(1, 0, 1, 0, 16'h0000, 16'h0000);

        // Reset while a store is waiting drops it.
        access(1, 1, 1, 0, 16'h0020, 16'h0000);
        @(negedge clk);
        sel = 1;
        rv = 1'b1;
        wr = 1'b1;
        sz = 1'b1;
        ad = 16'h0020;
        wd = 16'h1234;
        @(negedge clk);
        rv = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_quiet("midreset");
        access(1, 0, 1, 0, 16'h0020, 16'h0000);
        idle();

        // Zero wait states, back-to-back.
        access(0, 1, 1, 0, 16'h0030, 16'hA5C3);
        access(0, 0, 1, 0, 16'h0030, 16'h0000);
        access(0, 0, 1, 0, 16'h0030, 16'h0000);
        access(0, 0, 0, 1, 16'h0031, 16'h0000);
        idle();

        // Three wait states.
        access(2, 1, 1, 0, 16'h0040, 16'h5A5A);
        access(2, 0, 1, 0, 16'h0040, 16'h0000);
        access(2, 0, 0, 1, 16'h0041, 16'h0000);
        access(2, 0, 1, 0, 16'h0041, 16'h0000);
        access(2, 1, 0, 0, 16'h8040, 16'h00FF);
        access(2, 0, 1, 0, 16'h0040, 16'h0000);
        idle();

        // Fill a working region, then random traffic.
        for (int i = 0; i < 64; i++)
            access(1, 1, 1, 0, 16'(i * 2), 16'($urandom));
        for (int i = 0; i < 200; i++) begin
            w  = ($urandom_range(0, 2) == 0);
            s1 = 1'($urandom);
            s2 = 1'($urandom);
            a  = 16'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0)
                a = a | (16'h0001 << $urandom_range(10, 15));
            access(1, w, s1, s2, a, 16'($urandom));
        end
        idle();
        repeat (4) @(negedge clk);
        check("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
